// File: rtl/csd_div.sv
// csd_div: sequential signed divider, radix-2 restoring, one quotient bit
// per clock. Inverse of the 7x7 signed CSD multiplier: the 15-bit product
// width is the dividend, the 7-bit operand width is the divisor.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      request, sampled only while idle
//   dividend   15-bit signed numerator, captured on accepted start
//   divisor    7-bit signed denominator, captured on accepted start
//   busy       high while an operation is in progress
//   done       one-cycle pulse, results valid in that cycle
//   quotient   15-bit signed quotient, truncated toward zero
//   remainder  7-bit signed remainder, sign follows dividend
//   div_zero   divisor was zero for the presented result
//   overflow   quotient saturated (-16384 / -1 only)
//
// state | meaning
// IDLE  | waiting for start; results and flags held
// CALC  | 15 shift/trial-subtract iterations, counter 14 down to 0
// SIGN  | apply signs, saturation and divide-by-zero, register results

module csd_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [14:0] dividend,
    input  logic [6:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [14:0] quotient,
    output logic [6:0]  remainder,
    output logic        div_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [14:0] dvd_q, dvd_d;      // dividend magnitude, becomes quotient magnitude
    logic [6:0]  dsr_q, dsr_d;      // divisor magnitude, 0..64
    logic [7:0]  prem_q, prem_d;    // partial remainder
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] quotient_q, quotient_d;
    logic [6:0]  remainder_q, remainder_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;
    logic        overflow_q, overflow_d;

    // Shifted partial remainder is at most 2*63+1, so the trial compare on
    // 9 bits never wraps; the difference is below 64 and fits 8 bits.
    logic [8:0]  prem_shift;
    logic        trial_ge;
    logic [7:0]  trial_diff;

    assign prem_shift = {prem_q, dvd_q[14]};
    assign trial_ge   = (prem_shift >= {2'b00, dsr_q});
    assign trial_diff = prem_shift[7:0] - {1'b0, dsr_q};

    always_comb begin
        state_d     = state_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_quo_d = dividend[14] ^ divisor[6];
                    neg_rem_d = dividend[14];
                    // -16384 negates to 15'h4000, read as unsigned 16384
                    dvd_d     = dividend[14] ? -dividend : dividend;
                    dsr_d     = divisor[6] ? -divisor : divisor;
                    prem_d    = 8'd0;
                    cnt_d     = 4'd14;
                    state_d   = CALC;
                end
            end

            CALC: begin
                if (trial_ge) begin
                    prem_d = trial_diff;
                    dvd_d  = {dvd_q[13:0], 1'b1};
                end else begin
                    prem_d = prem_shift[7:0];
                    dvd_d  = {dvd_q[13:0], 1'b0};
                end
                if (cnt_q == 4'd0) begin
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SIGN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dsr_q == 7'd0) begin
                    quotient_d  = 15'd0;
                    remainder_d = 7'd0;
                    div_zero_d  = 1'b1;
                    overflow_d  = 1'b0;
                end else if (dvd_q == 15'h4000 && !neg_quo_q) begin
                    // +16384 is not representable; -16384 is, handled below
                    quotient_d  = 15'h3FFF;
                    remainder_d = 7'd0;
                    div_zero_d  = 1'b0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
                    remainder_d = neg_rem_q ? -prem_q[6:0] : prem_q[6:0];
                    div_zero_d  = 1'b0;
                    overflow_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dvd_q       <= 15'd0;
            dsr_q       <= 7'd0;
            prem_q      <= 8'd0;
            cnt_q       <= 4'd0;
            quotient_q  <= 15'd0;
            remainder_q <= 7'd0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/csd_div.md
Name: csd_div

Overview:
- Sequential signed divider; the inverse operation of the team's 7x7 signed CSD multiplier.
- Divides a 15-bit two's-complement dividend (the multiplier's product width) by a 7-bit two's-complement divisor (the multiplier's operand width).
- Returns a 15-bit quotient and 7-bit remainder using radix-2 restoring division, one quotient bit per cycle, behind a start/done handshake.

Parameters:
- None. Widths are fixed: dividend 15, divisor 7, quotient 15, remainder 7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- dividend  input  15  signed two's-complement numerator; captured on accepted start.
- divisor  input  7  signed two's-complement denominator; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid in that cycle.
- quotient  output  15  signed quotient, truncated toward zero.
- remainder  output  7  signed remainder; sign follows dividend.
- div_zero  output  1  divisor was 0 for the result presented with done.
- overflow  output  1  true quotient not representable (only -16384 / -1).

Behaviour:
- Reset: state IDLE; busy, done, div_zero, overflow = 0; quotient and remainder = 0; internal registers cleared. Reset mid-operation aborts the division with no done pulse; the operation is not resumed.
- States: IDLE, CALC, SIGN.
- IDLE: on an edge with start=1:
  - latch sign_q = dividend[14]^divisor[6] and sign_r = dividend[14];
  - latch |dividend| as 15-bit unsigned (0..16384) and |divisor| as 7-bit unsigned (0..64);
  - clear partial remainder (8 bits), load counter = 14, go to CALC.
- CALC, one iteration per edge:
  - shift {partial remainder, dividend magnitude} left by 1;
  - trial-subtract |divisor|; if non-negative, keep the difference and set the quotient LSB to 1, else restore and set it to 0;
  - after the iteration with counter = 0, go to SIGN; otherwise decrement counter.
- SIGN, one edge: register results, then go to IDLE.
  - quotient = sign_q ? -mag_q : mag_q; remainder = sign_r ? -mag_r : mag_r.
  - divisor = 0: quotient = 0, remainder = 0, div_zero = 1, overflow = 0. CALC still runs the full 15 cycles, so latency is fixed.
  - mag_q = 16384 with sign_q = 0 (only -16384 / -1): quotient = 15'h3FFF (saturate), remainder = 0, overflow = 1.
  - mag_q = 16384 with sign_q = 1 (e.g. -16384 / 1) is representable: quotient = 15'h4000, no flag.
  - |remainder| <= 63 always, so it fits 7-bit signed.
- busy = (state != IDLE); combinational from state.
- done: registered, high exactly for the cycle following the SIGN edge, when state is already IDLE.
- Latency: with start accepted on edge E, done is high in the cycle after edge E+16.
- Results and flags hold their values until the next SIGN edge or reset. Flags are rewritten every operation, never sticky.
- start while busy=1 is ignored; operands are not re-sampled.
- start asserted in the done cycle is accepted, giving back-to-back throughput of one result per 17 cycles.
- Arithmetic: negation of -16384 uses a 15-bit unsigned magnitude (16384 = 15'h4000 unsigned). Divisor magnitude 64 needs 7-bit unsigned. The partial remainder is 8 bits so the trial subtraction never wraps.

Test Plan:
- Basic signs: dividend=100, divisor=7 -> quotient=14, remainder=2. Then -100/7 -> q=-14, r=-2. Then 100/-7 -> q=-14, r=2. Each has done exactly 16 cycles after the start edge and busy high across the 16 cycles in between.
- Extremes: 16383/-64 -> q=-255, r=63. -16384/-64 -> q=256, r=0. -16384/1 -> q=-16384, r=0, overflow=0. -16384/-1 -> q=16383, r=0, overflow=1.
- Divide-by-zero: 1234/0 -> q=0, r=0, div_zero=1, same 16-cycle latency. A following 10/3 -> q=3, r=1, div_zero=0.
- Handshake: start held high continuously with operands changing each cycle -> only operands on accepted edges are used; results arrive every 17 cycles; no done pulse is dropped or duplicated.
- Reset mid-operation: assert reset 8 cycles after start -> next cycle busy=0, all outputs 0, no done. A new 50/5 afterwards -> q=10, r=0.
- Closed loop: random 7-bit x≠0 and y; feed dividend = x*y (15-bit product) with divisor = x -> quotient = y (sign-extended), remainder = 0, flags 0.
